// File: rtl/debounce_request_pkg.sv
// rtl/debounce_request_pkg.sv - shared state encodings and defaults for the request debouncer
package debounce_request_pkg;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_HIGH     = 2'd2,
    ST_FALL_CHK = 2'd3
  } state_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 4;
  localparam int DEFAULT_CNT_W           = 3;

  // Debounced level is high while the accepted state is high, including
  // while a falling change is still being qualified.
  function automatic logic level_of(state_t s);
    return (s == ST_HIGH) || (s == ST_FALL_CHK);
  endfunction

endpackage

// File: rtl/debounce_request_counter.sv
// rtl/debounce_request_counter.sv - qualification counter with clear, increment and terminal compare
module debounce_request_counter
  import debounce_request_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic last
);

  localparam logic [CNT_W:0] TERM = (CNT_W+1)'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Count qualifying ticks; the FSM never increments past DEBOUNCE_CYCLES-1.
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
    end
  end

  // This tick completes the run when one more sample reaches the threshold.
  assign last = (({1'b0, cnt} + 1'b1) == TERM);

endmodule

// File: rtl/debounce_request.sv
// rtl/debounce_request.sv - debounces a synchronized input into level, edge pulses and a sticky request
module debounce_request
  import debounce_request_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEFAULT_CNT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic in_sync,
  input  logic ack,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic request
);

  state_t state_q, state_n;
  logic   cnt_clr, cnt_inc, cnt_last;
  logic   press_set, release_set;

  debounce_request_counter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_counter (
    .clock(clock),
    .reset(reset),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .last (cnt_last)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_LOW;
    end else begin
      state_q <= state_n;
    end
  end

  // Next state and counter control; nothing moves between ticks.
  always_comb begin
    state_n = state_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    if (tick) begin
      case (state_q)
        ST_LOW: begin
          if (in_sync) begin
            if (cnt_last) begin
              state_n = ST_HIGH;
              cnt_clr = 1'b1;
            end else begin
              state_n = ST_RISE_CHK;
              cnt_inc = 1'b1;
            end
          end
        end
        ST_RISE_CHK: begin
          if (!in_sync) begin
            state_n = ST_LOW;
            cnt_clr = 1'b1;
          end else if (cnt_last) begin
            state_n = ST_HIGH;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        ST_HIGH: begin
          if (!in_sync) begin
            if (cnt_last) begin
              state_n = ST_LOW;
              cnt_clr = 1'b1;
            end else begin
              state_n = ST_FALL_CHK;
              cnt_inc = 1'b1;
            end
          end
        end
        ST_FALL_CHK: begin
          if (in_sync) begin
            state_n = ST_HIGH;
            cnt_clr = 1'b1;
          end else if (cnt_last) begin
            state_n = ST_LOW;
            cnt_clr = 1'b1;
          end else begin
            cnt_inc = 1'b1;
          end
        end
        default: begin
          state_n = ST_LOW;
          cnt_clr = 1'b1;
        end
      endcase
    end
  end

  // A bounce back into the current level does not count as an edge.
  assign press_set   = (state_n == ST_HIGH) &&
                       ((state_q == ST_LOW) || (state_q == ST_RISE_CHK));
  assign release_set = (state_n == ST_LOW) &&
                       ((state_q == ST_HIGH) || (state_q == ST_FALL_CHK));

  // Registered outputs; a new press wins over a same-edge ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      request       <= 1'b0;
    end else begin
      level         <= level_of(state_n);
      press_pulse   <= press_set;
      release_pulse <= release_set;
      request       <= press_set || (request && !ack);
    end
  end

endmodule
